// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared state, opcode and select encodings for the datapath controller
package ctrl_pkg;

  typedef enum logic [2:0] {
    S_WAIT,
    S_DECODE,
    S_GET_A,
    S_GET_B,
    S_EXEC,
    S_WB_REG,
    S_WB_IMM
  } state_t;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_MVN = 2'b11;

  localparam logic [1:0] VSEL_C   = 2'b00;
  localparam logic [1:0] VSEL_IMM = 2'b01;

endpackage

// File: rtl/instr_decoder.sv
// rtl/instr_decoder.sv - splits the instruction register into fields and flags supported encodings
module instr_decoder
  import ctrl_pkg::*;
#(
  parameter int DW = 16,
  parameter int RW = 3
) (
  input  logic [DW-1:0] ir,
  output logic [2:0]    opcode,
  output logic [1:0]    op,
  output logic [RW-1:0] rn,
  output logic [RW-1:0] rd,
  output logic [RW-1:0] rm,
  output logic [1:0]    shift,
  output logic [DW-1:0] sximm8,
  output logic          legal
);

  assign opcode = ir[15:13];
  assign op     = ir[12:11];
  assign rn     = ir[10:8];
  assign rd     = ir[7:5];
  assign shift  = ir[4:3];
  assign rm     = ir[2:0];
  assign sximm8 = {{(DW-8){ir[7]}}, ir[7:0]};

  // Every ALU op is supported; MOV only has the immediate and register forms.
  assign legal = (opcode == OPC_ALU) ||
                 ((opcode == OPC_MOV) && ((op == OP_MOV_IMM) || (op == OP_MOV_REG)));

endmodule

// File: rtl/datapath_ctrl.sv
// rtl/datapath_ctrl.sv - multi-cycle Moore sequencer driving the register-file/shifter/ALU datapath
module datapath_ctrl
  import ctrl_pkg::*;
#(
  parameter int DW = 16,
  parameter int RW = 3
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          s,
  input  logic [DW-1:0] in,
  output logic          w,
  output logic [RW-1:0] readnum,
  output logic [RW-1:0] writenum,
  output logic          write,
  output logic [1:0]    vsel,
  output logic          loada,
  output logic          loadb,
  output logic          loadc,
  output logic          loads,
  output logic          asel,
  output logic [1:0]    shift,
  output logic [1:0]    ALUop,
  output logic [DW-1:0] sximm8,
  output logic          illegal
);

  state_t        state, next;
  logic [DW-1:0] ir;
  logic [2:0]    opcode;
  logic [1:0]    op, ir_shift;
  logic [RW-1:0] rn, rd, rm;
  logic          legal, write_en;

  instr_decoder #(.DW(DW), .RW(RW)) u_dec (
    .ir    (ir),
    .opcode(opcode),
    .op    (op),
    .rn    (rn),
    .rd    (rd),
    .rm    (rm),
    .shift (ir_shift),
    .sximm8(sximm8),
    .legal (legal)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= S_WAIT;
      ir    <= '0;
    end else begin
      state <= next;
      if (state == S_WAIT && s) ir <= in;
    end
  end

  // A reset arriving during a writeback cycle must suppress that write too.
  assign write = write_en && reset_n;

  always_comb begin
    next     = state;
    w        = 1'b0;
    readnum  = '0;
    writenum = '0;
    write_en = 1'b0;
    vsel     = VSEL_C;
    loada    = 1'b0;
    loadb    = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    asel     = 1'b0;
    shift    = 2'b00;
    ALUop    = ALU_ADD;
    illegal  = 1'b0;
    case (state)
      S_WAIT: begin
        w = 1'b1;
        if (s) next = S_DECODE;
      end
      S_DECODE: begin
        if (!legal) begin
          illegal = 1'b1;
          next    = S_WAIT;
        end else if (opcode == OPC_MOV) begin
          next = (op == OP_MOV_IMM) ? S_WB_IMM : S_GET_B;
        end else begin
          next = (op == ALU_MVN) ? S_GET_B : S_GET_A;
        end
      end
      S_GET_A: begin
        readnum = rn;
        loada   = 1'b1;
        next    = S_GET_B;
      end
      S_GET_B: begin
        readnum = rm;
        loadb   = 1'b1;
        shift   = ir_shift;
        next    = S_EXEC;
      end
      S_EXEC: begin
        shift = ir_shift;
        if (opcode == OPC_MOV) begin
          // MOV reg passes the shifted B operand through as 0 + B.
          asel  = 1'b1;
          ALUop = ALU_ADD;
          loadc = 1'b1;
          next  = S_WB_REG;
        end else begin
          ALUop = op;
          if (op == ALU_SUB) begin
            loads = 1'b1;
            next  = S_WAIT;
          end else begin
            loadc = 1'b1;
            next  = S_WB_REG;
          end
        end
      end
      S_WB_REG: begin
        write_en = 1'b1;
        vsel     = VSEL_C;
        writenum = rd;
        next     = S_WAIT;
      end
      S_WB_IMM: begin
        write_en = 1'b1;
        vsel     = VSEL_IMM;
        writenum = rn;
        next     = S_WAIT;
      end
      default: next = S_WAIT;
    endcase
  end

endmodule

// File: tb/tb_datapath_ctrl.sv
// tb/tb_datapath_ctrl.sv - randomized self-checking bench for datapath_ctrl against a per-instruction step model
module tb_datapath_ctrl;

  typedef struct packed {
    logic       w;
    logic [2:0] readnum;
    logic [2:0] writenum;
    logic       write;
    logic [1:0] vsel;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       asel;
    logic [1:0] shift;
    logic [1:0] aluop;
    logic       illegal;
  } obs_t;

  logic        clk = 1'b0;
  logic        reset_n, s;
  logic [15:0] in_w;
  logic        w, write, loada, loadb, loadc, loads, asel, illegal;
  logic [2:0]  readnum, writenum;
  logic [1:0]  vsel, shift, alu_op;
  logic [15:0] sximm8;

  int   n_vec = 0;
  int   n_bad = 0;
  obs_t exp_q[$];

  always #5 clk = ~clk;

  datapath_ctrl #(.DW(16), .RW(3)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .s       (s),
    .in      (in_w),
    .w       (w),
    .readnum (readnum),
    .writenum(writenum),
    .write   (write),
    .vsel    (vsel),
    .loada   (loada),
    .loadb   (loadb),
    .loadc   (loadc),
    .loads   (loads),
    .asel    (asel),
    .shift   (shift),
    .ALUop   (alu_op),
    .sximm8  (sximm8),
    .illegal (illegal)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic obs_t observe();
    obs_t o;
    o.w = w;           o.readnum = readnum; o.writenum = writenum;
    o.write = write;   o.vsel = vsel;       o.loada = loada;
    o.loadb = loadb;   o.loadc = loadc;     o.loads = loads;
    o.asel = asel;     o.shift = shift;     o.aluop = alu_op;
    o.illegal = illegal;
    return o;
  endfunction

  // Lists the control vector of every cycle following acceptance, ending with the idle cycle.
  task automatic build(input logic [15:0] ir);
    obs_t       r;
    logic [2:0] opc, rn, rd, rm;
    logic [1:0] op, sh;
    logic       mov_imm, mov_reg, alu, is_cmp;
    opc = ir[15:13]; op = ir[12:11]; rn = ir[10:8];
    rd  = ir[7:5];   sh = ir[4:3];   rm = ir[2:0];
    mov_imm = (opc == 3'b110) && (op == 2'b10);
    mov_reg = (opc == 3'b110) && (op == 2'b00);
    alu     = (opc == 3'b101);
    is_cmp  = alu && (op == 2'b01);
    exp_q.delete();
    r = '0;
    r.illegal = !(mov_imm || mov_reg || alu);
    exp_q.push_back(r);
    if (mov_imm) begin
      r = '0; r.write = 1'b1; r.vsel = 2'b01; r.writenum = rn;
      exp_q.push_back(r);
    end else if (mov_reg || alu) begin
      if (alu && op != 2'b11) begin
        r = '0; r.readnum = rn; r.loada = 1'b1;
        exp_q.push_back(r);
      end
      r = '0; r.readnum = rm; r.loadb = 1'b1; r.shift = sh;
      exp_q.push_back(r);
      r = '0; r.shift = sh;
      r.aluop = mov_reg ? 2'b00 : op;
      r.asel  = mov_reg;
      r.loads = is_cmp;
      r.loadc = !is_cmp;
      exp_q.push_back(r);
      if (!is_cmp) begin
        r = '0; r.write = 1'b1; r.writenum = rd;
        exp_q.push_back(r);
      end
    end
    r = '0; r.w = 1'b1;
    exp_q.push_back(r);
  endtask

  // Caller guarantees the DUT is idle and the bench sits away from a rising edge.
  task automatic run_instr(input logic [15:0] ir, input bit noisy);
    logic [15:0] sx;
    int          last;
    sx = {{8{ir[7]}}, ir[7:0]};
    build(ir);
    last = exp_q.size() - 1;
    in_w = ir;
    s    = 1'b1;
    @(posedge clk);
    for (int k = 0; k <= last; k++) begin
      #1;
      if (noisy && k != last) begin
        s    = 1'($urandom % 2);
        in_w = 16'($urandom);
      end else begin
        s = 1'b0;
      end
      @(negedge clk);
      check_eq($sformatf("ir%h c%0d ctl", ir, k), 32'(observe()), 32'(exp_q[k]));
      check_eq($sformatf("ir%h c%0d sximm8", ir, k), 32'(sximm8), 32'(sx));
      if (k != last) @(posedge clk);
    end
  endtask

  task automatic reset_mid_add();
    in_w = 16'hA148;
    s    = 1'b1;
    @(posedge clk);
    #1 s = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1'b0;
    @(negedge clk);
    check_eq("rst_getb write", 32'(write), 32'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_eq($sformatf("rst_after c%0d w", k), 32'(w), 32'd1);
      check_eq($sformatf("rst_after c%0d write", k), 32'(write), 32'd0);
      check_eq($sformatf("rst_after c%0d sximm8", k), 32'(sximm8), 32'd0);
      @(posedge clk);
    end
    @(negedge clk);
  endtask

  initial begin
    obs_t        idle;
    logic [15:0] r;
    idle   = '0;
    idle.w = 1'b1;
    reset_n = 1'b0;
    s       = 1'b1;
    in_w    = 16'($urandom);
    @(posedge clk);
    @(negedge clk);
    check_eq("reset ctl", 32'(observe()), 32'(idle));
    check_eq("reset sximm8", 32'(sximm8), 32'd0);
    reset_n = 1'b1;
    s       = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_eq("post_reset ctl", 32'(observe()), 32'(idle));

    run_instr(16'hD1FE, 1'b0);
    run_instr(16'hA148, 1'b0);
    run_instr(16'hA900, 1'b0);
    run_instr(16'hB860, 1'b1);
    run_instr(16'hE000, 1'b0);
    reset_mid_add();

    for (int i = 0; i < 200; i++) begin
      r = 16'($urandom);
      case ($urandom % 4)
        0, 1:    r[15:13] = 3'b101;
        2:       r[15:13] = 3'b110;
        default: ;
      endcase
      run_instr(r, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/datapath_ctrl.md
Name: datapath_ctrl

Overview:
- Multi-cycle Moore FSM that sequences the 16-bit register-file/shifter/ALU datapath. The ALU encoding is ADD=00, SUB=01, AND=10, MVN=11, and the ALU has a Z flag.
- Latches one instruction on a start strobe, decodes it, and drives the datapath load, select, read and write controls cycle by cycle.
- Sits between the instruction source (switches, later the fetch unit) and the datapath.
- Asserts w when idle and ready for the next instruction.

Parameters:
- DW, 16, datapath and instruction width.
- RW, 3, register-number width (8 registers).

Ports:
- clk  in  1  Rising-edge clock.
- reset_n  in  1  Synchronous, active-low reset.
- s  in  1  Start strobe; sampled only in WAIT.
- in  in  DW  Instruction word; captured into IR when s=1 in WAIT.
- w  out  1  1 only in WAIT.
- readnum  out  RW  Register-file read address.
- writenum  out  RW  Register-file write address.
- write  out  1  Register-file write enable.
- vsel  out  2  Writeback source select: 00 = C, 01 = sximm8, others reserved.
- loada, loadb, loadc, loads  out  1 each  Datapath register enables.
- asel  out  1  1 forces the ALU A operand to 0.
- shift  out  2  Shifter control, taken from IR[4:3].
- ALUop  out  2  ALU operation.
- sximm8  out  DW  IR[7:0] sign-extended to 16 bits.
- illegal  out  1  1-cycle pulse when an unsupported opcode is decoded.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-low: reset_n=0 at a rising edge forces state to WAIT and IR to 0.
- Reset values: w=1, and every other output is 0 (sximm8=0, since IR=0).
- Reset mid-instruction: abort, with no write in that cycle or after. Reset has priority over s.
- IR field layout:
  - [15:13] opcode
  - [12:11] op
  - [10:8] Rn
  - [7:5] Rd
  - [4:3] shift
  - [2:0] Rm
- Supported instructions:
  - MOV Rn,#imm8: opcode 110, op 10.
  - MOV Rd,Rm{,sh}: opcode 110, op 00.
  - ADD: opcode 101, op 00.
  - CMP: opcode 101, op 01.
  - AND: opcode 101, op 10.
  - MVN: opcode 101, op 11.
- States: WAIT, DECODE, GET_A, GET_B, EXEC, WB_REG, WB_IMM.
- Transitions:
  - WAIT: if s, load IR and go to DECODE; else stay.
  - DECODE:
    - MOV imm goes to WB_IMM.
    - ADD, CMP and AND go to GET_A.
    - MOV reg and MVN go to GET_B.
    - Anything else: illegal=1, go to WAIT.
  - GET_A: readnum=Rn, loada=1; go to GET_B.
  - GET_B: readnum=Rm, loadb=1; go to EXEC.
  - EXEC:
    - ALUop=op, shift=IR[4:3].
    - MOV reg: asel=1, ALUop=00.
    - CMP: loads=1, go to WAIT.
    - All others: loadc=1, go to WB_REG.
  - WB_REG: write=1, vsel=00, writenum=Rd; go to WAIT.
  - WB_IMM: write=1, vsel=01, writenum=Rn; go to WAIT.
- Outputs not listed for a state are 0. shift is driven from IR in GET_B and EXEC and is 0 elsewhere. sximm8 is always a combinational function of IR.
- Latency from the s edge to w=1:
  - MOV imm: 3 cycles.
  - MOV reg / MVN: 5 cycles.
  - ADD / AND: 6 cycles.
  - CMP: 5 cycles.
- s while w=0 is ignored. IR is held stable until the next accepted s.
- s held high continuously: a new instruction is accepted on each WAIT cycle; there is no edge detection.
- The default state branch goes to WAIT, so there are no lockup states.

Decomposition:
- Package ctrl_pkg holds:
  - The state_t enum.
  - Opcode constants: OPC_MOV=3'b110, OPC_ALU=3'b101.
  - ALU op constants: ALU_ADD, ALU_SUB, ALU_AND, ALU_MVN.
  - VSEL_C and VSEL_IMM.
- Sub-module instr_decoder: combinational; IR in; opcode, op, Rn, Rd, Rm, shift, sximm8 and legal out.

Test Plan:
- reset_n=0 for 1 edge with s=1 -> w=1, write=0, all loads 0, IR=0. Still in WAIT after release if s=0.
- in=16'hD1FE (MOV R1,#-2), s pulse -> 2nd cycle after the accepting edge: write=1, vsel=01, writenum=1, sximm8=16'hFFFE. w=1 on the 3rd cycle.
- in=16'hA148 (ADD R2,R1,R0 LSL#1) -> each state for exactly one cycle, in order:
  - readnum=1 with loada=1.
  - readnum=0 with loadb=1, shift=01.
  - ALUop=00 with loadc=1.
  - write=1 with writenum=2, vsel=00.
- in=16'hA900 (CMP R1,R0) -> EXEC has ALUop=01, loads=1, loadc=0. write never asserts. w=1 five cycles after the accepting edge.
- in=16'hB860 (MVN R3,R0) -> no loada. GET_B has readnum=0. EXEC has ALUop=11. WB_REG has writenum=3. Pulsing s mid-instruction has no effect.
- in=16'hE000 -> illegal=1 for one cycle in DECODE, no write or loads, back in WAIT. Separately: reset_n=0 during GET_B of an ADD -> next cycle in WAIT, write never asserts.
